// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: takes X/Y one bit pair per cycle
// over a valid/ready stream and reports one-hot X>Y, X==Y, X<Y.
//
// Ports:
//   inClk, inRstN       clock, async active-low reset
//   inStart             begin (or restart) a comparison
//   inValid             inBitX/inBitY hold a bit pair this cycle
//   inBitX, inBitY      serial operand bits
//   outReady            bit pair accepted this cycle when inValid
//   outBusy             comparison in progress
//   outCount            bit pairs accepted so far
//   outDone             1-cycle pulse, result flags updated
//   outBig/outSame/outSmall  result of last completed comparison
module serial_magnitude_comparator #(
  parameter int WIDTH     = 2,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic          inClk,
  input  logic          inRstN,
  input  logic          inStart,
  input  logic          inValid,
  input  logic          inBitX,
  input  logic          inBitY,
  output logic          outReady,
  output logic          outBusy,
  output logic [CW-1:0] outCount,
  output logic          outDone,
  output logic          outBig,
  output logic          outSame,
  output logic          outSmall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    D_EQ,
    D_GT,
    D_LT
  } dec_t;

  localparam logic [CW-1:0] LAST_IDX =
    CW'(WIDTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  dec_t          r_dec;
  dec_t          w_dec_nxt;
  dec_t          w_dec_upd;
  dec_t          w_pair_dec;
  logic          r_big;
  logic          r_same;
  logic          r_small;

  logic          w_shift;
  logic          w_accept;
  logic          w_last;
  logic          w_diff;
  logic          w_take;

  assign w_shift  = (r_state == S_SHIFT);
  // A restart pulse wins over a pair in the
  // same cycle; that pair is dropped.
  assign w_accept = w_shift & inValid
                  & ~inStart;
  assign w_last   = w_accept
                  & (r_count == LAST_IDX);
  assign w_diff   = inBitX ^ inBitY;

  assign w_pair_dec = inBitX ? D_GT : D_LT;

  // MSB-first: the first difference decides.
  // LSB-first: the latest difference is the
  // most significant one seen, so it wins.
  assign w_take = w_accept & w_diff
                & (!MSB_FIRST || r_dec == D_EQ);

  assign w_dec_upd = w_take ? w_pair_dec
                            : r_dec;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dec_nxt   = r_dec;
    unique case (r_state)
      S_IDLE: begin
        if (inStart) begin
          w_state_nxt = S_SHIFT;
          w_count_nxt = '0;
          w_dec_nxt   = D_EQ;
        end
      end
      S_SHIFT: begin
        if (inStart) begin
          w_count_nxt = '0;
          w_dec_nxt   = D_EQ;
        end else if (w_accept) begin
          w_count_nxt = r_count + 1'b1;
          w_dec_nxt   = w_dec_upd;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (inStart) begin
          w_state_nxt = S_SHIFT;
          w_count_nxt = '0;
          w_dec_nxt   = D_EQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_dec   <= D_EQ;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  // Flags load with the final decision as the
  // last pair is accepted, so they are valid
  // in the DONE cycle and held afterwards.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_big   <= 1'b0;
      r_same  <= 1'b0;
      r_small <= 1'b0;
    end else if (w_last) begin
      r_big   <= (w_dec_upd == D_GT);
      r_same  <= (w_dec_upd == D_EQ);
      r_small <= (w_dec_upd == D_LT);
    end
  end

  assign outReady = w_shift;
  assign outBusy  = (r_state != S_IDLE);
  assign outDone  = (r_state == S_DONE);
  assign outCount = r_count;
  assign outBig   = r_big;
  assign outSame  = r_same;
  assign outSmall = r_small;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomized bench for serial_magnitude_comparator
// against an integer-compare reference model.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] st, vl, bx, by;
  wire  [1:0] rdy, bsy, dn, bg, sm, sl;
  wire  [1:0] cnt0;
  wire  [2:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  int dn_seen [2];
  int dn_exp  [2];
  int inshift [2];
  logic [2:0] prev [2];

  always #5 clk = ~clk;

  serial_magnitude_comparator #(
    .WIDTH(2), .MSB_FIRST(1'b1)
  ) u_msb (
    .inClk(clk), .inRstN(rst_n),
    .inStart(st[0]), .inValid(vl[0]),
    .inBitX(bx[0]), .inBitY(by[0]),
    .outReady(rdy[0]), .outBusy(bsy[0]),
    .outCount(cnt0), .outDone(dn[0]),
    .outBig(bg[0]), .outSame(sm[0]),
    .outSmall(sl[0])
  );

  serial_magnitude_comparator #(
    .WIDTH(4), .MSB_FIRST(1'b0)
  ) u_lsb (
    .inClk(clk), .inRstN(rst_n),
    .inStart(st[1]), .inValid(vl[1]),
    .inBitX(bx[1]), .inBitY(by[1]),
    .outReady(rdy[1]), .outBusy(bsy[1]),
    .outCount(cnt1), .outDone(dn[1]),
    .outBig(bg[1]), .outSame(sm[1]),
    .outSmall(sl[1])
  );

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (dn[d] === 1'b1) dn_seen[d]++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  function automatic int wid(int d);
    return d ? 4 : 2;
  endfunction

  function automatic logic [31:0] cnt(int d);
    return d ? {29'd0, cnt1} : {30'd0, cnt0};
  endfunction

  function automatic logic [31:0] flg(int d);
    return {29'd0, bg[d], sm[d], sl[d]};
  endfunction

  function automatic logic [2:0] model(int x,
                                       int y);
    return {x > y, x == y, x < y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(int d);
    st[d] = 1'b1;
    vl[d] = 1'b0;
    tick();
    st[d] = 1'b0;
    chk("start_ready", 32'(rdy[d]), 1);
    chk("start_busy", 32'(bsy[d]), 1);
    chk("start_cnt", cnt(d), 0);
    chk("start_done", 32'(dn[d]), 0);
    chk("start_flags", flg(d), 32'(prev[d]));
    inshift[d] = 1;
  endtask

  // gaps < 0: random stalls before each pair;
  // gaps >= 0: that many stalls before pairs
  // after the first.
  task automatic feed(int d, int x, int y,
                      int gaps);
    int w, b, g;
    w = wid(d);
    for (int i = 0; i < w; i++) begin
      g = (gaps < 0) ? $urandom_range(0, 2)
        : (i == 0 ? 0 : gaps);
      repeat (g) begin
        vl[d] = 1'b0;
        bx[d] = 1'($urandom);
        by[d] = 1'($urandom);
        tick();
        chk("stall_cnt", cnt(d), i);
        chk("stall_ready", 32'(rdy[d]), 1);
        chk("stall_done", 32'(dn[d]), 0);
      end
      b = (d == 0) ? (w - 1 - i) : i;
      vl[d] = 1'b1;
      bx[d] = 1'(x >> b);
      by[d] = 1'(y >> b);
      tick();
      chk("acc_cnt", cnt(d), i + 1);
      if (i < w - 1) begin
        chk("acc_ready", 32'(rdy[d]), 1);
        chk("acc_done", 32'(dn[d]), 0);
        chk("acc_hold", flg(d), 32'(prev[d]));
      end
    end
    vl[d] = 1'b0;
    prev[d] = model(x, y);
    dn_exp[d]++;
    chk("done", 32'(dn[d]), 1);
    chk("done_busy", 32'(bsy[d]), 1);
    chk("done_ready", 32'(rdy[d]), 0);
    chk("result", flg(d), 32'(prev[d]));
  endtask

  task automatic to_idle(int d);
    tick();
    inshift[d] = 0;
    chk("idle_done", 32'(dn[d]), 0);
    chk("idle_busy", 32'(bsy[d]), 0);
    chk("idle_cnt", cnt(d), wid(d));
    chk("idle_flags", flg(d), 32'(prev[d]));
  endtask

  task automatic b2b(int d);
    st[d] = 1'b1;
    tick();
    st[d] = 1'b0;
    inshift[d] = 1;
    chk("b2b_ready", 32'(rdy[d]), 1);
    chk("b2b_cnt", cnt(d), 0);
    chk("b2b_done", 32'(dn[d]), 0);
    chk("b2b_hold", flg(d), 32'(prev[d]));
  endtask

  initial begin
    int x, y, w;
    rst_n = 1'b0;
    st = '0; vl = '0; bx = '0; by = '0;
    for (int d = 0; d < 2; d++) begin
      prev[d] = 3'b000;
      dn_seen[d] = 0;
      dn_exp[d] = 0;
      inshift[d] = 0;
    end
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_flags", flg(d), 0);
      chk("rst_busy", 32'(bsy[d]), 0);
      chk("rst_cnt", cnt(d), 0);
      chk("rst_done", 32'(dn[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // all 16 operand pairs back-to-back
    start_pulse(0);
    for (int k = 0; k < 16; k++) begin
      feed(0, k >> 2, k & 3, 0);
      if (k < 15) b2b(0);
    end
    to_idle(0);

    // LSB-first 0110 vs 0101
    start_pulse(1);
    feed(1, 6, 5, 0);
    chk("lsb_big", flg(1), 32'b100);
    to_idle(1);

    // stall pattern 1,0,0,1 with equal values
    start_pulse(0);
    feed(0, 3, 3, 2);
    chk("stall_same", flg(0), 32'b010);
    to_idle(0);

    // abort after one pair
    start_pulse(0);
    vl[0] = 1'b1; bx[0] = 1'b1; by[0] = 1'b0;
    tick();
    chk("abort_pre_cnt", cnt(0), 1);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    vl[0] = 1'b0;
    chk("abort_cnt", cnt(0), 0);
    chk("abort_ready", 32'(rdy[0]), 1);
    chk("abort_done", 32'(dn[0]), 0);
    feed(0, 0, 1, 0);
    chk("abort_small", flg(0), 32'b001);
    to_idle(0);

    // async reset mid-comparison
    start_pulse(0);
    vl[0] = 1'b1; bx[0] = 1'b0; by[0] = 1'b1;
    tick();
    chk("rm_cnt", cnt(0), 1);
    vl[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rm_flags", flg(d), 0);
      chk("rm_busy", 32'(bsy[d]), 0);
      chk("rm_ready", 32'(rdy[d]), 0);
      chk("rm_cnt0", cnt(d), 0);
      chk("rm_done", 32'(dn[d]), 0);
      prev[d] = 3'b000;
      inshift[d] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    vl[0] = 1'b1;
    repeat (3) begin
      tick();
      chk("rm_ign_cnt", cnt(0), 0);
      chk("rm_ign_busy", 32'(bsy[0]), 0);
    end
    vl[0] = 1'b0;

    // randomized traffic on both instances
    for (int k = 0; k < 80; k++) begin
      int d;
      d = k % 2;
      w = wid(d);
      x = $urandom_range(0, (1 << w) - 1);
      y = ($urandom_range(0, 3) == 0) ? x
        : $urandom_range(0, (1 << w) - 1);
      if (inshift[d] == 0) start_pulse(d);
      feed(d, x, y, -1);
      if ($urandom_range(0, 1) == 1) b2b(d);
      else to_idle(d);
    end
    for (int d = 0; d < 2; d++) begin
      if (inshift[d] != 0) begin
        feed(d, 1, 0, 0);
        to_idle(d);
      end
    end

    tick();
    for (int d = 0; d < 2; d++)
      chk("done_pulses", dn_seen[d], dn_exp[d]);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
